// File: rtl/uart_rx_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_mmio_pkg
//  Brief    : Shared register map, status bit indices, FSM encoding and
//             divisor helper for the memory-mapped UART receiver.
//  Revision : 1.0
// ============================================================================
package uart_rx_mmio_pkg;

    localparam logic UART_DATA   = 1'b0;
    localparam logic UART_STATUS = 1'b1;

    localparam int ST_OVR = 4;
    localparam int ST_FRM = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    function automatic int calc_divisor(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with extra-bit pointers and a combinational
//             head output; push on full is accepted only alongside a pop.
//  Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_count  = r_wr_ptr - r_rd_ptr;
    assign o_head   = r_mem[r_rd_ptr[c_AW-1:0]];

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_mmio
//  Brief    : 8N1 UART receiver with byte FIFO behind a two-register MMIO slot.
//  Revision : 1.0
// ============================================================================
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx,
    input  logic        req,
    input  logic        wren,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int          c_DIVISOR  = calc_divisor(CLOCK_RATE, BAUD_RATE);
    localparam int          c_CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_FULL_BIT = 16'(c_DIVISOR - 1);
    localparam logic [15:0] c_HALF_BIT = 16'(c_DIVISOR / 2 - 1);

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shreg;
    logic            r_ovr;
    logic            r_frm;

    logic            w_tick;
    logic            w_fall;
    logic            w_load_half;
    logic            w_load_full;
    logic            w_shift;
    logic            w_bit_clr;
    logic            w_push;
    logic            w_frm_set;

    logic            w_rd_data;
    logic            w_rd_status;
    logic            w_wr_status;
    logic            w_pop;
    logic            w_ovr_set;
    logic [7:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [c_CW-1:0] w_count;
    logic [7:0]      w_count_ext;
    logic            w_unused_bits;

    assign w_tick = (r_baud == 16'd0);
    assign w_fall = !r_rx_sync && r_rx_prev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_state_next = S_START;
            S_START: if (w_tick) w_state_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_tick) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_bit_clr   = 1'b0;
        w_push      = 1'b0;
        w_frm_set   = 1'b0;
        case (r_state)
            S_IDLE:  w_load_half = w_fall;
            S_START: begin
                w_load_full = w_tick && !r_rx_sync;
                w_bit_clr   = w_tick && !r_rx_sync;
            end
            S_DATA:  begin
                w_shift     = w_tick;
                w_load_full = w_tick;
            end
            S_STOP:  begin
                w_push      = w_tick && r_rx_sync;
                w_frm_set   = w_tick && !r_rx_sync;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shreg <= 8'd0;
        end else begin
            if (w_load_half)      r_baud <= c_HALF_BIT;
            else if (w_load_full) r_baud <= c_FULL_BIT;
            else if (!w_tick)     r_baud <= r_baud - 16'd1;

            if (w_bit_clr)        r_bit <= 3'd0;
            else if (w_shift)     r_bit <= r_bit + 3'd1;

            // Line order is LSB first, so bits enter at the top and walk down.
            if (w_shift)          r_shreg <= {r_rx_sync, r_shreg[7:1]};
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (r_shreg),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_rd_data   = req && !wren && (addr == UART_DATA);
    assign w_rd_status = req && !wren && (addr == UART_STATUS);
    assign w_wr_status = req &&  wren && (addr == UART_STATUS);
    assign w_pop       = w_rd_data && !w_empty;
    assign w_ovr_set   = w_push && w_full && !w_pop;
    assign w_count_ext = 8'(w_count);
    assign w_unused_bits = ^{wdata[31:6], wdata[3:0], w_count_ext[7:4]};

    // Set events take priority over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovr <= 1'b0;
            r_frm <= 1'b0;
        end else begin
            if (w_ovr_set)                        r_ovr <= 1'b1;
            else if (w_wr_status && wdata[ST_OVR]) r_ovr <= 1'b0;

            if (w_frm_set)                        r_frm <= 1'b1;
            else if (w_wr_status && wdata[ST_FRM]) r_frm <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= 32'd0;
        end else if (w_rd_data) begin
            rdata <= {23'd0, !w_empty, (w_empty ? 8'd0 : w_head)};
        end else if (w_rd_status) begin
            rdata <= {26'd0, r_frm, r_ovr, w_count_ext[3:0]};
        end else begin
            rdata <= 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_mmio
//  Brief    : Self-checking bench: queue-based receiver model plus directed
//             and randomized serial/bus traffic at 16 clocks per bit.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_mmio;

    localparam int D        = 16;
    localparam int DEPTH    = 8;
    // Edges from driving the start bit low to the stop-bit sample:
    // one capture edge, two synchronizer stages, half a bit, nine full bits.
    localparam int PUSH_LAT = 3 + D/2 + 9*D;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        rx    = 1'b1;
    logic        req   = 1'b0;
    logic        wren  = 1'b0;
    logic        addr  = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    uart_rx_mmio #(
        .CLOCK_RATE (D * 9600),
        .BAUD_RATE  (9600),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .rx    (rx),
        .req   (req),
        .wren  (wren),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    typedef struct {
        int         edge_no;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          serial_done;
    ev_t         evq[$];
    logic [7:0]  mq[$];
    bit          m_ovr = 1'b0;
    bit          m_frm = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    int          m_sz;
    bit          m_ovr_set;
    bit          m_frm_set;
    ev_t         m_ev;
    logic [31:0] d;

    // Reference model: FIFO as a queue, frames arrive as timed events.
    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            mq.delete();
            evq.delete();
            m_ovr   = 1'b0;
            m_frm   = 1'b0;
            m_rdata = 32'd0;
        end else begin
            m_sz      = mq.size();
            m_ovr_set = 1'b0;
            m_frm_set = 1'b0;
            if (req && !wren && addr == 1'b0) begin
                if (m_sz > 0) begin
                    m_rdata = {23'd0, 1'b1, mq[0]};
                    void'(mq.pop_front());
                end else begin
                    m_rdata = 32'd0;
                end
            end else if (req && !wren && addr == 1'b1) begin
                m_rdata = {26'd0, m_frm, m_ovr, 4'(m_sz)};
            end else begin
                m_rdata = 32'd0;
            end
            while (evq.size() > 0 && evq[0].edge_no <= cyc) begin
                m_ev = evq.pop_front();
                if (!m_ev.ok)                m_frm_set = 1'b1;
                else if (mq.size() < DEPTH)  mq.push_back(m_ev.data);
                else                         m_ovr_set = 1'b1;
            end
            if (req && wren && addr == 1'b1) begin
                if (wdata[4]) m_ovr = 1'b0;
                if (wdata[5]) m_frm = 1'b0;
            end
            if (m_ovr_set) m_ovr = 1'b1;
            if (m_frm_set) m_frm = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL rdata_model cyc=%0d actual=%h expected=%h", cyc, rdata, m_rdata);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        tick(1);
        rx = 1'b0;
        evq.push_back('{cyc + PUSH_LAT, b, stop_ok});
        for (int i = 0; i < 8; i++) begin
            tick(D);
            rx = b[i];
        end
        tick(D);
        rx = stop_ok;
        tick(D);
        rx = 1'b1;
    endtask

    task automatic bus_rd(input logic a, output logic [31:0] q);
        req  = 1'b1;
        wren = 1'b0;
        addr = a;
        tick(1);
        req  = 1'b0;
        q    = rdata;
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] v);
        req   = 1'b1;
        wren  = 1'b1;
        addr  = a;
        wdata = v;
        tick(1);
        req   = 1'b0;
        wren  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check_lit("reset_rdata", rdata, 32'h0);
        rstn = 1'b1;
        tick(2);
        bus_rd(1'b1, d); check_lit("reset_status", d, 32'h0);

        send_frame(8'hA5, 1'b1);
        tick(2);
        bus_rd(1'b0, d); check_lit("rd_A5", d, 32'h1A5);
        bus_rd(1'b0, d); check_lit("rd_empty", d, 32'h0);

        rx = 1'b0; tick(3); rx = 1'b1;
        tick(2*D);
        bus_rd(1'b1, d); check_lit("glitch_status", d, 32'h0);

        send_frame(8'h00, 1'b0);
        tick(D);
        bus_rd(1'b1, d); check_lit("frm_status", d, 32'h20);
        bus_wr(1'b1, 32'h20);
        bus_rd(1'b1, d); check_lit("frm_cleared", d, 32'h0);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        tick(2);
        bus_rd(1'b1, d); check_lit("ovr_status", d, 32'h18);
        for (int i = 1; i <= 8; i++) begin
            bus_rd(1'b0, d); check_lit("ovr_drain", d, 32'h100 + i);
        end
        bus_wr(1'b1, 32'h10);
        bus_rd(1'b1, d); check_lit("ovr_cleared", d, 32'h0);

        for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b1);
        fork
            send_frame(8'h48, 1'b1);
            begin
                logic [31:0] q;
                tick(1);
                tick(PUSH_LAT - 1);
                bus_rd(1'b0, q); check_lit("coincident_rd", q, 32'h140);
            end
        join
        tick(2);
        bus_rd(1'b1, d); check_lit("coincident_status", d, 32'h08);
        for (int i = 1; i <= 8; i++) begin
            bus_rd(1'b0, d); check_lit("full_drain", d, 32'h140 + i);
        end

        fork
            send_frame(8'h99, 1'b1);
            begin
                tick(60);
                rstn = 1'b0;
                tick(1);
                check_lit("midbyte_rst_rdata", rdata, 32'h0);
                tick(110);
                rstn = 1'b1;
            end
        join
        tick(2);
        bus_rd(1'b1, d); check_lit("post_rst_status", d, 32'h0);
        send_frame(8'h3C, 1'b1);
        tick(2);
        bus_rd(1'b0, d); check_lit("post_rst_3C", d, 32'h13C);

        serial_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
                    tick($urandom_range(1, 20));
                end
                serial_done = 1'b1;
            end
            begin
                while (!serial_done) begin
                    req   = ($urandom_range(0, 3) == 0);
                    wren  = ($urandom_range(0, 4) == 0);
                    addr  = 1'($urandom);
                    wdata = $urandom;
                    tick(1);
                end
                req  = 1'b0;
                wren = 1'b0;
            end
        join
        for (int i = 0; i < DEPTH + 1; i++) bus_rd(1'b0, d);
        bus_rd(1'b1, d);
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
